// File: rtl/sample_logger.sv
// Post-filter sample logger: captures DEPTH enabled samples after a start command,
// then exposes the buffer through a registered read port while idle or full.
module sample_logger #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_ADDR = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_start,
  input  logic               i_rd_en,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic               o_busy,
  output logic               o_full,
  output logic [NB_ADDR:0]   o_count
);

  localparam int unsigned Depth = 1 << NB_ADDR;

  typedef enum logic [1:0] {StIdle, StCapture, StFull} state_e;

  state_e             state_q, state_d;
  logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [NB_ADDR:0]   count_q, count_d;
  logic               wr_en;
  logic               rd_accept;
  logic [NB_DATA-1:0] rd_data_q;
  logic               rd_valid_q;
  logic               busy_q;
  logic               full_q;

  logic [NB_DATA-1:0] mem [Depth];

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wr_en     = 1'b0;
    // Reads are blocked while capturing, so the RAM never sees read-during-write.
    rd_accept = i_rd_en && (state_q != StCapture);
    case (state_q)
      StIdle, StFull: begin
        if (i_start) begin
          state_d  = StCapture;
          wr_ptr_d = '0;
          count_d  = '0;
        end
      end
      StCapture: begin
        // A start always wins, even over the final write of the buffer.
        if (i_start) begin
          wr_ptr_d = '0;
          count_d  = '0;
        end else if (i_enable) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + NB_ADDR'(1);
          count_d  = count_q + (NB_ADDR + 1)'(1);
          if (&wr_ptr_q) begin
            state_d = StFull;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      busy_q     <= (state_d == StCapture);
      full_q     <= (state_d == StFull);
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_data_q <= mem[i_rd_addr];
      end
    end
  end

  // Storage is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge i_clock) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= i_data;
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_busy     = busy_q;
  assign o_full     = full_q;
  assign o_count    = count_q;

endmodule

// File: tb/tb_sample_logger.sv
// Scoreboard bench for sample_logger: a queue/array reference model predicts status
// and read results; a negedge monitor compares them against the DUT.
module tb_sample_logger;

  localparam int NbData = 8;
  localparam int NbAddr = 3;
  localparam int Depth  = 8;
  localparam int MIdle  = 0;
  localparam int MCap   = 1;
  localparam int MFull  = 2;

  logic              i_clock = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_enable = 1'b0;
  logic [NbData-1:0] i_data = '0;
  logic              i_start = 1'b0;
  logic              i_rd_en = 1'b0;
  logic [NbAddr-1:0] i_rd_addr = '0;
  logic [NbData-1:0] o_rd_data;
  logic              o_rd_valid;
  logic              o_busy;
  logic              o_full;
  logic [NbAddr:0]   o_count;

  sample_logger #(
    .NB_DATA(NbData),
    .NB_ADDR(NbAddr)
  ) dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_data    (i_data),
    .i_start   (i_start),
    .i_rd_en   (i_rd_en),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data),
    .o_rd_valid(o_rd_valid),
    .o_busy    (o_busy),
    .o_full    (o_full),
    .o_count   (o_count)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [NbData-1:0] data;
    bit                care;
  } exp_t;

  int                checks = 0;
  int                failures = 0;
  exp_t              rd_q[$];
  int                m_mode = MIdle;
  int                m_count = 0;
  logic [NbData-1:0] m_mem [Depth];
  bit                m_known [Depth];
  logic [NbData-1:0] hold = '0;
  bit                hold_known = 1'b1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void reset_model();
    m_mode     = MIdle;
    m_count    = 0;
    hold       = '0;
    hold_known = 1'b1;
    rd_q.delete();
  endfunction

  // Advance one clock and update the reference model from the inputs sampled at that edge.
  task automatic step();
    @(posedge i_clock);
    if (!i_reset) begin
      reset_model();
    end else begin
      if (m_mode != MCap && i_rd_en) begin
        rd_q.push_back('{data: m_mem[i_rd_addr], care: m_known[i_rd_addr]});
      end
      if (i_start) begin
        m_mode  = MCap;
        m_count = 0;
      end else if (m_mode == MCap && i_enable) begin
        m_mem[m_count]   = i_data;
        m_known[m_count] = 1'b1;
        m_count++;
        if (m_count == Depth) m_mode = MFull;
      end
    end
    #1;
  endtask

  task automatic drive(input bit en, input logic [NbData-1:0] d, input bit st, input bit rd,
                       input logic [NbAddr-1:0] addr);
    i_enable  = en;
    i_data    = d;
    i_start   = st;
    i_rd_en   = rd;
    i_rd_addr = addr;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic read_all();
    for (int a = 0; a < Depth; a++) drive(1'b0, '0, 1'b0, 1'b1, a[NbAddr-1:0]);
    idle(1);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_rd_data"}, o_rd_data, 0);
    chk({tag, "_rd_valid"}, o_rd_valid, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_full"}, o_full, 0);
    chk({tag, "_count"}, o_count, 0);
  endtask

  always @(negedge i_clock) begin
    exp_t e;
    chk("busy", o_busy, (m_mode == MCap));
    chk("full", o_full, (m_mode == MFull));
    chk("count", o_count, m_count);
    chk("rd_valid", o_rd_valid, (rd_q.size() != 0));
    if (rd_q.size() != 0) begin
      e = rd_q.pop_front();
      if (e.care) begin
        chk("rd_data", o_rd_data, e.data);
        hold = e.data;
      end else begin
        hold = o_rd_data;
      end
      hold_known = 1'b1;
    end else if (hold_known) begin
      chk("rd_hold", o_rd_data, hold);
    end
  end

  initial begin
    for (int a = 0; a < Depth; a++) m_known[a] = 1'b0;

    // Power-on reset
    #2 i_reset = 1'b0;
    reset_model();
    #1 check_reset_outputs("por");
    step();
    step();
    i_reset = 1'b1;
    idle(2);

    // Basic capture of 10..17, then single read of address 3
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    for (int k = 0; k < Depth; k++) drive(1'b1, NbData'(10 + k), 1'b0, 1'b0, '0);
    idle(2);
    drive(1'b0, '0, 1'b0, 1'b1, 3'd3);
    chk("basic_rd_valid", o_rd_valid, 1);
    chk("basic_rd_data", o_rd_data, 13);
    idle(2);

    // Alternating enable; then back-to-back reads of all addresses
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 2 * Depth; k++)
      drive((k % 2) == 0, NbData'(8'h20 + k / 2), 1'b0, 1'b0, '0);
    chk("alt_full", o_full, 1);
    read_all();

    // Restart after 5 writes with enable high: that sample is dropped
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 5; k++) drive(1'b1, NbData'(8'h40 + k), 1'b0, 1'b0, '0);
    drive(1'b1, 8'hEE, 1'b1, 1'b0, '0);
    chk("restart_count", o_count, 0);
    for (int k = 0; k < Depth; k++) drive(1'b1, NbData'(8'h50 + k), 1'b0, 1'b0, '0);
    read_all();

    // Reads during capture are ignored
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 3; k++) drive(1'b1, NbData'(8'h60 + k), 1'b0, 1'b0, '0);
    drive(1'b1, 8'h63, 1'b0, 1'b1, 3'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd2);
    for (int k = 4; k < Depth; k++) drive(1'b1, NbData'(8'h60 + k), 1'b0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, 1'b1, 3'd2);
    idle(1);

    // Asynchronous reset mid-capture at count 4
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 4; k++) drive(1'b1, NbData'(8'h70 + k), 1'b0, 1'b0, '0);
    i_enable = 1'b1;
    i_data   = 8'h99;
    #1 i_reset = 1'b0;
    reset_model();
    #1 check_reset_outputs("async");
    step();
    #2 i_reset = 1'b1;
    for (int k = 0; k < 4; k++) drive(1'b1, NbData'(8'hA0 + k), 1'b0, 1'b0, '0);
    read_all();

    // Randomised traffic
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 500; k++) begin
      drive(($urandom_range(0, 9) < 7), NbData'($urandom), ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 1) == 1), NbAddr'($urandom));
    end
    idle(2);
    chk("queue_drained", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
